// File: rtl/miter_seq_ctrl.sv
// miter_seq_ctrl: stimulus/compare sequencer for bounded equivalence checking
// of a golden (A) and a revised (B) netlist that share one input bus.
// Sequence per run: FLUSH (all-zero input) -> RUN (one vector per cycle) ->
// DRAIN (all-zero input while the last vectors reach the outputs) -> DONE.
// OUT_A/OUT_B are compared LAT cycles after each vector is driven; the first
// difference is captured and ends the run early.
// Build option: define MITER_LFSR_EN to take vectors from a 16-bit Fibonacci
// LFSR (taps 16,14,13,11, seed 16'hACE1) instead of the binary vector index.
module miter_seq_ctrl #(
    parameter int IN_W      = 2,
    parameter int OUT_W     = 4,
    parameter int LAT       = 1,
    parameter int FLUSH_CYC = 2,
    parameter int NUM_VEC   = 4,
    parameter int CNT_W     = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    output logic [IN_W-1:0]  DUT_IN,
    input  logic [OUT_W-1:0] OUT_A,
    input  logic [OUT_W-1:0] OUT_B,
    output logic             BUSY,
    output logic             DONE,
    output logic             MISMATCH,
    output logic [CNT_W-1:0] FAIL_VEC,
    output logic [OUT_W-1:0] FAIL_DIFF
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FLUSH = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // One phase counter serves both FLUSH and DRAIN, so size it for the longer.
    localparam int              PH_MAX     = (FLUSH_CYC > LAT) ? FLUSH_CYC : LAT;
    localparam int              PH_W       = (PH_MAX < 2) ? 1 : $clog2(PH_MAX);
    localparam logic [PH_W-1:0] FLUSH_LAST = PH_W'(FLUSH_CYC - 1);
    localparam logic [PH_W-1:0] DRAIN_LAST = PH_W'(LAT - 1);
    localparam logic [CNT_W-1:0] K_LAST    = CNT_W'(NUM_VEC - 1);

    logic [2:0]       state_q, state_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic [IN_W-1:0]  dut_in_q, dut_in_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             mismatch_q, mismatch_d;
    logic [CNT_W-1:0] fail_vec_q, fail_vec_d;
    logic [OUT_W-1:0] fail_diff_q, fail_diff_d;

    // Tag (valid, k) of the vector whose response is on OUT_A/OUT_B this cycle.
    logic             cmp_v;
    logic [CNT_W-1:0] cmp_k;

`ifdef MITER_LFSR_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    logic [15:0] lfsr_q, lfsr_d, lfsr_src;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction
`endif

    generate
        if (LAT == 0) begin : g_no_pipe
            // Combinational pair: the response belongs to the vector driven now.
            assign cmp_v = (state_q == S_RUN);
            assign cmp_k = k_q;
        end else begin : g_pipe
            logic [LAT-1:0]   v_q, v_d;
            logic [CNT_W-1:0] kp_q [LAT];
            logic [CNT_W-1:0] kp_d [LAT];
            logic             pipe_clr;

            // Stale tags must not leak into the next run, so empty the pipe
            // whenever the sequencer leaves the busy states.
            assign pipe_clr = (state_d == S_IDLE) || (state_d == S_DONE);

            // Shift the tag of the vector on DUT_IN one stage per cycle.
            always_comb begin
                v_d  = v_q;
                kp_d = kp_q;
                if (pipe_clr) begin
                    v_d = '0;
                end else begin
                    v_d[0]  = (state_q == S_RUN);
                    kp_d[0] = k_q;
                    for (int i = 1; i < LAT; i++) begin
                        v_d[i]  = v_q[i-1];
                        kp_d[i] = kp_q[i-1];
                    end
                end
            end

            // Tag pipeline registers.
            // NOTE: the pipe is a handful of flops, not a RAM, so it is reset
            // with everything else; only true memories are left unreset.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    v_q <= '0;
                    for (int i = 0; i < LAT; i++) begin
                        kp_q[i] <= '0;
                    end
                end else begin
                    v_q  <= v_d;
                    kp_q <= kp_d;
                end
            end

            assign cmp_v = v_q[LAT-1];
            assign cmp_k = kp_q[LAT-1];
        end
    endgenerate

    // Next-state, compare and output-register logic.
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        k_d         = k_q;
        mismatch_d  = mismatch_q;
        fail_vec_d  = fail_vec_q;
        fail_diff_d = fail_diff_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    mismatch_d  = 1'b0;
                    fail_vec_d  = '0;
                    fail_diff_d = '0;
                    ph_d        = '0;
                    k_d         = '0;
                    if (FLUSH_CYC == 0) state_d = S_RUN;
                    else                state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (ph_q == FLUSH_LAST) begin
                    state_d = S_RUN;
                    ph_d    = '0;
                    k_d     = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            S_RUN: begin
                // Stop on the terminal count; k never wraps.
                if (k_q == K_LAST) begin
                    ph_d = '0;
                    if (LAT == 0) state_d = S_DONE;
                    else          state_d = S_DRAIN;
                end else begin
                    k_d = k_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (ph_q == DRAIN_LAST) state_d = S_DONE;
                else                    ph_d    = ph_q + PH_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        // The first difference ends the run; leaving the busy states also
        // discards any compares still in flight.
        if (busy_q && cmp_v && (OUT_A != OUT_B)) begin
            mismatch_d  = 1'b1;
            fail_vec_d  = cmp_k;
            fail_diff_d = OUT_A ^ OUT_B;
            state_d     = S_DONE;
        end

        busy_d = (state_d == S_FLUSH) || (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);

`ifdef MITER_LFSR_EN
        // Outside a run the LFSR sits at the seed, so a run starts from it
        // whether or not a FLUSH phase precedes the first vector.
        lfsr_src = ((state_q == S_IDLE) || (state_q == S_DONE)) ? LFSR_SEED : lfsr_q;
        lfsr_d   = lfsr_src;
        dut_in_d = '0;
        if (state_d == S_RUN) begin
            dut_in_d = IN_W'(lfsr_src);
            lfsr_d   = lfsr_step(lfsr_src);
        end
`else
        dut_in_d = (state_d == S_RUN) ? IN_W'(k_d) : '0;
`endif
    end

    // State and output registers.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            ph_q        <= '0;
            k_q         <= '0;
            dut_in_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mismatch_q  <= 1'b0;
            fail_vec_q  <= '0;
            fail_diff_q <= '0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            k_q         <= k_d;
            dut_in_q    <= dut_in_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mismatch_q  <= mismatch_d;
            fail_vec_q  <= fail_vec_d;
            fail_diff_q <= fail_diff_d;
        end
    end

`ifdef MITER_LFSR_EN
    // Vector-source LFSR register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_d;
    end
`endif

    assign DUT_IN    = dut_in_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign MISMATCH  = mismatch_q;
    assign FAIL_VEC  = fail_vec_q;
    assign FAIL_DIFF = fail_diff_q;

endmodule

// File: tb/tb_miter_seq_ctrl.sv
// Bench for miter_seq_ctrl: two sequencers, one driving a combinational
// NAND pair (LAT=0, 1-bit outputs, k counter exactly NUM_VEC wide) and one
// driving a 4-bit-output pair behind two DFF stages (LAT=2). Revised-circuit
// faults are planted on a chosen input value with a chosen output mask.
module tb_miter_seq_ctrl;

    localparam int C_FL = 2, C_LAT = 0, C_NV = 4, C_CW = 2;
    localparam int S_FL = 3, S_LAT = 2, S_CW = 8;
`ifdef MITER_LFSR_EN
    localparam int S_NV = 200;
`else
    localparam int S_NV = 6;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              c_start = 1'b0, s_start = 1'b0;
    logic [1:0]        c_dut_in, s_dut_in;
    logic [0:0]        c_out_a, c_out_b, c_fail_diff;
    logic [3:0]        s_out_a, s_out_b, s_fail_diff;
    logic              c_busy, c_done, c_mm, s_busy, s_done, s_mm;
    logic [C_CW-1:0]   c_fail_vec;
    logic [S_CW-1:0]   s_fail_vec;

    int         c_fault_in = -1, s_fault_in = -1;
    logic [0:0] c_fault_mask = '0;
    logic [3:0] s_fault_mask = '0;

    miter_seq_ctrl #(.IN_W(2), .OUT_W(1), .LAT(C_LAT), .FLUSH_CYC(C_FL),
                     .NUM_VEC(C_NV), .CNT_W(C_CW)) u_comb (
        .CLK(clk), .RST_N(rst_n), .START(c_start), .DUT_IN(c_dut_in),
        .OUT_A(c_out_a), .OUT_B(c_out_b), .BUSY(c_busy), .DONE(c_done),
        .MISMATCH(c_mm), .FAIL_VEC(c_fail_vec), .FAIL_DIFF(c_fail_diff));

    miter_seq_ctrl #(.IN_W(2), .OUT_W(4), .LAT(S_LAT), .FLUSH_CYC(S_FL),
                     .NUM_VEC(S_NV), .CNT_W(S_CW)) u_seq (
        .CLK(clk), .RST_N(rst_n), .START(s_start), .DUT_IN(s_dut_in),
        .OUT_A(s_out_a), .OUT_B(s_out_b), .BUSY(s_busy), .DONE(s_done),
        .MISMATCH(s_mm), .FAIL_VEC(s_fail_vec), .FAIL_DIFF(s_fail_diff));

    // Pair 1: A = nand, B = not(and), with an optional planted fault.
    always_comb begin
        c_out_a = ~(c_dut_in[0] & c_dut_in[1]);
        c_out_b = ~{c_dut_in[0] & c_dut_in[1]} ^ ((int'(c_dut_in) == c_fault_in) ? c_fault_mask : 1'b0);
    end

    // Pair 2: two DFF stages, then four gate functions of the delayed input.
    logic [1:0] s_d1, s_d2;
    logic [3:0] s_fn;
    always @(posedge clk) begin
        s_d1 <= s_dut_in;
        s_d2 <= s_d1;
    end
    always_comb begin
        s_fn    = {~(s_d2[0] & s_d2[1]), s_d2[0] ^ s_d2[1], s_d2[0] | s_d2[1], ~s_d2[0]};
        s_out_a = s_fn;
        s_out_b = s_fn ^ ((int'(s_d2) == s_fault_in) ? s_fault_mask : 4'h0);
    end

    // Selected-instance view used by the generic run task.
    int         sel = 0;
    logic       x_busy, x_done, x_mm;
    logic [1:0] x_dut_in;
    logic [7:0] x_fail_vec;
    logic [3:0] x_fail_diff;
    always_comb begin
        if (sel == 0) begin
            x_busy = c_busy; x_done = c_done; x_mm = c_mm; x_dut_in = c_dut_in;
            x_fail_vec = 8'(c_fail_vec); x_fail_diff = 4'(c_fail_diff);
        end else begin
            x_busy = s_busy; x_done = s_done; x_mm = s_mm; x_dut_in = s_dut_in;
            x_fail_vec = s_fail_vec; x_fail_diff = s_fail_diff;
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference vector source.
`ifdef MITER_LFSR_EN
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction
    function automatic logic [1:0] stim(input int k);
        logic [15:0] s = 16'hACE1;
        for (int i = 0; i < k; i++) s = lfsr_next(s);
        return s[1:0];
    endfunction
`else
    function automatic logic [1:0] stim(input int k);
        logic [31:0] kk = k;
        return kk[1:0];
    endfunction
`endif

    function automatic int p_fl(input int s);  return (s == 0) ? C_FL  : S_FL;  endfunction
    function automatic int p_lat(input int s); return (s == 0) ? C_LAT : S_LAT; endfunction
    function automatic int p_nv(input int s);  return (s == 0) ? C_NV  : S_NV;  endfunction

    typedef struct {
        int         sel;
        int         fault_in;
        logic [3:0] mask;
        bit         poke;
        logic       exp_mm;
        int         exp_vec;
        logic [3:0] exp_diff;
        int         exp_busy;
    } vec_t;

    // Expected result: first vector whose input hits the planted fault.
    function automatic vec_t make_case(input int s, input int fin, input logic [3:0] m, input bit poke);
        vec_t t;
        int   fk = -1;
        for (int k = 0; k < p_nv(s); k++) begin
            if (fk < 0 && int'(stim(k)) == fin) fk = k;
        end
        t.sel = s; t.fault_in = fin; t.mask = m; t.poke = poke;
        t.exp_mm   = (fk >= 0);
        t.exp_vec  = (fk >= 0) ? fk : 0;
        t.exp_diff = (fk >= 0) ? m : 4'h0;
        t.exp_busy = p_fl(s) + ((fk >= 0) ? fk + 1 : p_nv(s)) + p_lat(s);
        return t;
    endfunction

    task automatic run_case(input vec_t t, input int idx);
        logic [1:0] q[$];
        int cyc;
        sel = t.sel;
        c_fault_in = (t.sel == 0) ? t.fault_in : -1;
        c_fault_mask = t.mask[0:0];
        s_fault_in = (t.sel == 1) ? t.fault_in : -1;
        s_fault_mask = t.mask;
        @(negedge clk);
        for (int i = 0; i < t.exp_busy; i++) begin
            int j = i - p_fl(t.sel);
            q.push_back((j < 0 || j >= p_nv(t.sel)) ? 2'b00 : stim(j));
        end
        if (t.sel == 0) c_start = 1'b1; else s_start = 1'b1;
        @(negedge clk);
        c_start = 1'b0; s_start = 1'b0;
        check($sformatf("case%0d cleared_on_start", idx), 32'({x_mm, x_done, x_fail_vec, x_fail_diff}), 32'h0);
        cyc = 0;
        while (x_busy === 1'b1 && cyc < 500) begin
            if (t.poke && cyc == 2) begin
                if (t.sel == 0) c_start = 1'b1; else s_start = 1'b1;
            end
            if (q.size() > 0) check($sformatf("case%0d dut_in[%0d]", idx, cyc), 32'(x_dut_in), 32'(q.pop_front()));
            cyc++;
            @(negedge clk);
            c_start = 1'b0; s_start = 1'b0;
        end
        check($sformatf("case%0d busy_cycles", idx), 32'(cyc), 32'(t.exp_busy));
        check($sformatf("case%0d unused_vectors", idx), 32'(q.size()), 32'd0);
        check($sformatf("case%0d done", idx), 32'(x_done), 32'd1);
        check($sformatf("case%0d mismatch", idx), 32'(x_mm), 32'(t.exp_mm));
        check($sformatf("case%0d fail_vec", idx), 32'(x_fail_vec), 32'(t.exp_vec));
        check($sformatf("case%0d fail_diff", idx), 32'(x_fail_diff), 32'(t.exp_diff));
        check($sformatf("case%0d dut_in_idle", idx), 32'(x_dut_in), 32'd0);
        repeat (2) @(negedge clk);
        check($sformatf("case%0d hold", idx), 32'({x_busy, x_done, x_mm, x_fail_vec, x_fail_diff}),
              32'({1'b0, 1'b1, t.exp_mm, 8'(t.exp_vec), t.exp_diff}));
    endtask

    vec_t tbl[8];
    int   seen;

    initial begin
        tbl[0] = make_case(0, -1, 4'h0, 1'b0);  // equivalent comb pair
        tbl[1] = make_case(0,  0, 4'h1, 1'b0);  // fails on the very first vector
        tbl[2] = make_case(1, -1, 4'h0, 1'b1);  // equivalent DFF pair, START while busy
        tbl[3] = make_case(1,  0, 4'h1, 1'b0);  // fault also visible during FLUSH
        tbl[4] = make_case(0, -1, 4'h0, 1'b0);  // restart from DONE after a failure
        tbl[5] = make_case(1,  2, 4'hA, 1'b0);  // multi-bit difference mid-run
        tbl[6] = make_case(0,  3, 4'h1, 1'b1);  // fault on the terminal vector
        tbl[7] = make_case(1,  1, 4'h8, 1'b0);  // single high-bit difference

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset comb", 32'({c_busy, c_done, c_mm, c_fail_vec, c_fail_diff, c_dut_in}), 32'h0);
        check("reset seq", 32'({s_busy, s_done, s_mm, s_fail_vec, s_fail_diff, s_dut_in}), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_case(tbl[i], i);

        // Asynchronous reset during RUN cycle 3 of the DFF pair.
        sel = 1; s_fault_in = -1;
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        repeat (S_FL + 3) @(negedge clk);
        check("abort busy_before", 32'(s_busy), 32'd1);
        check("abort dut_in_before", 32'(s_dut_in), 32'(stim(3)));
        #2 rst_n = 1'b0;
        #1;
        check("abort seq_outputs", 32'({s_busy, s_done, s_mm, s_fail_vec, s_fail_diff, s_dut_in}), 32'h0);
        check("abort comb_outputs", 32'({c_busy, c_done, c_mm, c_fail_vec, c_fail_diff, c_dut_in}), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (s_done || s_busy || c_done || c_busy) seen++;
        end
        check("abort no_done", 32'(seen), 32'd0);

        // START together with reset: reset wins.
        @(negedge clk); rst_n = 1'b0; c_start = 1'b1; s_start = 1'b1;
        @(negedge clk);
        check("start_in_reset busy", 32'({c_busy, s_busy}), 32'd0);
        c_start = 1'b0; s_start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("after_reset idle", 32'({c_busy, s_busy, c_done, s_done}), 32'd0);

        run_case(tbl[0], 8);
        run_case(tbl[2], 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
